// File: rtl/blink_timebase.sv
// Timebase for the blinker: prescaled running count, one-hot rate mask, start/stop with free-run/burst/single-step modes.
// Latency: config latches on the accepting edge; first tick lands prescale+1 clocks after the start edge; tick/done/count/mask are registered.
// Backpressure: cfg_ready is high only in IDLE; a cfg_valid seen in RUN or DONE is dropped with no side effect.
module blink_timebase #(
    parameter int PRESCALE_W = 8,
    parameter int COUNT_W    = 16,
    parameter int BURST_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic [3:0]            cfg_rate,
    input  logic [1:0]            cfg_mode,
    input  logic [BURST_W-1:0]    cfg_bursts,
    input  logic                  start,
    input  logic                  stop,
    output logic [COUNT_W-1:0]    current_count,
    output logic [COUNT_W-1:0]    mask,
    output logic                  tick,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [3:0]            rate_q, rate_d;
    logic [1:0]            mode_q, mode_d;
    logic [BURST_W-1:0]    bursts_q, bursts_d;
    logic [BURST_W-1:0]    bursts_left_q, bursts_left_d;
    logic [COUNT_W-1:0]    mask_q, mask_d;
    logic                  tick_q, tick_d;
    logic                  done_q, done_d;

    // Mode 3 is an alias of free-run, so only burst and single-step need decoding.
    logic                  mode_burst;
    logic                  mode_step;
    // All ones from bit 0 up to and including bit rate_q; a period ends when the count matches this.
    logic [COUNT_W-1:0]    low_ones;
    logic                  period_end;
    logic                  prescale_hit;

    assign mode_burst   = (mode_q == 2'd1);
    assign mode_step    = (mode_q == 2'd2);
    assign low_ones     = {COUNT_W{1'b1}} >> (4'd15 - rate_q);
    assign period_end   = ((count_q & low_ones) == low_ones);
    assign prescale_hit = (pre_q == prescale_q);

    assign cfg_ready     = (state_q == S_IDLE);
    assign busy          = (state_q == S_RUN);
    assign current_count = count_q;
    assign mask          = mask_q;
    assign tick          = tick_q;
    assign done          = done_q;

    // State and datapath registers; reset is asynchronous so a mid-run reset clears at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            pre_q         <= '0;
            prescale_q    <= '0;
            rate_q        <= '0;
            mode_q        <= '0;
            bursts_q      <= '0;
            bursts_left_q <= '0;
            mask_q        <= {{(COUNT_W-1){1'b0}}, 1'b1};
            tick_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pre_q         <= pre_d;
            prescale_q    <= prescale_d;
            rate_q        <= rate_d;
            mode_q        <= mode_d;
            bursts_q      <= bursts_d;
            bursts_left_q <= bursts_left_d;
            mask_q        <= mask_d;
            tick_q        <= tick_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic; tick and done default low so they are single-cycle pulses.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pre_d         = pre_q;
        prescale_d    = prescale_q;
        rate_d        = rate_q;
        mode_d        = mode_q;
        bursts_d      = bursts_q;
        bursts_left_d = bursts_left_q;
        mask_d        = mask_q;
        tick_d        = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // New config lands at this edge; a simultaneous start below still reads the old registers.
                if (cfg_valid) begin
                    prescale_d = cfg_prescale;
                    rate_d     = cfg_rate;
                    mode_d     = cfg_mode;
                    bursts_d   = cfg_bursts;
                    mask_d     = {{(COUNT_W-1){1'b0}}, 1'b1} << cfg_rate;
                end
                // stop beats start when both are high.
                if (start && !stop) begin
                    if (mode_step) begin
                        count_d = count_q + 1'b1;
                        tick_d  = 1'b1;
                    end else begin
                        count_d       = '0;
                        pre_d         = '0;
                        bursts_left_d = bursts_q;
                        state_d       = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (mode_burst && (bursts_left_q == '0)) begin
                    // Zero-length burst: finish immediately without counting.
                    if (!stop) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (prescale_hit) begin
                    pre_d   = '0;
                    count_d = count_q + 1'b1;
                    tick_d  = 1'b1;
                    if (mode_burst && period_end) begin
                        bursts_left_d = bursts_left_q - 1'b1;
                        if ((bursts_left_q == {{(BURST_W-1){1'b0}}, 1'b1}) && !stop) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                // A tick on the same edge as stop still counts; only the state is forced.
                if (stop) begin
                    state_d = S_IDLE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_blink_timebase.sv
module tb_blink_timebase;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_prescale;
    logic [3:0]  cfg_rate;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_bursts;
    logic        start;
    logic        stop;
    logic [15:0] current_count;
    logic [15:0] mask;
    logic        tick;
    logic        busy;
    logic        done;

    int tests_run;
    int tests_failed;
    int done_pulses;

    blink_timebase dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_prescale  (cfg_prescale),
        .cfg_rate      (cfg_rate),
        .cfg_mode      (cfg_mode),
        .cfg_bursts    (cfg_bursts),
        .start         (start),
        .stop          (stop),
        .current_count (current_count),
        .mask          (mask),
        .tick          (tick),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] r, input logic [1:0] m, input logic [7:0] b);
        cfg_valid    = 1'b1;
        cfg_prescale = p;
        cfg_rate     = r;
        cfg_mode     = m;
        cfg_bursts   = b;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        done_pulses  = 0;
        rst          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_prescale = '0;
        cfg_rate     = '0;
        cfg_mode     = '0;
        cfg_bursts   = '0;
        start        = 1'b0;
        stop         = 1'b0;

        // Reset values
        #12;
        chk("rst_count", current_count, 16'h0000);
        chk("rst_mask", mask, 16'h0001);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rel_count", current_count, 16'h0000);
        chk("rel_mask", mask, 16'h0001);
        chk("rel_cfg_ready", cfg_ready, 1'b1);
        chk("rel_busy", busy, 1'b0);
        chk("rel_tick", tick, 1'b0);
        chk("rel_done", done, 1'b0);

        // Free-run, prescale 3, rate 2
        do_cfg(8'd3, 4'd2, 2'd0, 8'd0);
        chk("fr_mask", mask, 16'h0004);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("fr_busy", busy, 1'b1);
        chk("fr_count0", current_count, 16'd0);
        // Config offered during RUN must be refused and not latched.
        cfg_valid    = 1'b1;
        cfg_prescale = 8'd0;
        cfg_rate     = 4'd1;
        cfg_mode     = 2'd1;
        cfg_bursts   = 8'd3;
        chk("run_cfg_ready", cfg_ready, 1'b0);
        step(); step();
        chk("fr_c2_tick", tick, 1'b0);
        step();
        chk("fr_c3_count", current_count, 16'd0);
        step();
        chk("fr_c4_count", current_count, 16'd1);
        chk("fr_c4_tick", tick, 1'b1);
        chk("run_mask_held", mask, 16'h0004);
        step();
        chk("fr_c5_tick", tick, 1'b0);
        step(); step(); step();
        chk("fr_c8_count", current_count, 16'd2);
        chk("fr_c8_tick", tick, 1'b1);
        step(); step(); step(); step();
        chk("fr_c12_count", current_count, 16'd3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_count", current_count, 16'd3);
        chk("stop_mask_still_old", mask, 16'h0004);
        chk("stop_cfg_ready", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("idle_cfg_accept_mask", mask, 16'h0002);

        // Burst: prescale 0, rate 1, 3 bursts (accepted above)
        start = 1'b1;
        step();
        start = 1'b0;
        chk("bu_busy", busy, 1'b1);
        chk("bu_count0", current_count, 16'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (done) done_pulses++;
            if (k == 3)  chk("bu_count3", current_count, 16'd3);
            if (k == 7)  chk("bu_count7", current_count, 16'd7);
            if (k == 11) chk("bu_count11", current_count, 16'd11);
            if (k == 11) chk("bu_busy11", busy, 1'b1);
        end
        chk("bu_done_at12", done, 1'b1);
        chk("bu_count12", current_count, 16'd12);
        chk("bu_done_pulses", done_pulses, 1);
        step();
        chk("bu_done_clear", done, 1'b0);
        chk("bu_idle_busy", busy, 1'b0);
        chk("bu_idle_ready", cfg_ready, 1'b1);
        step();
        chk("bu_count_held", current_count, 16'd12);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", current_count, 16'd0);
        chk("arst_mask", mask, 16'h0001);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-step: five start pulses
        do_cfg(8'd0, 4'd0, 2'd2, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk("ss_tick", tick, 1'b1);
            chk("ss_busy", busy, 1'b0);
            chk("ss_count", current_count, 32'(i));
            step();
            chk("ss_tick_low", tick, 1'b0);
        end
        chk("ss_count5", current_count, 16'd5);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_startstop_count", current_count, 16'd5);
        chk("ss_startstop_tick", tick, 1'b0);
        do_cfg(8'd0, 4'd0, 2'd0, 8'd0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("fr_startstop_busy", busy, 1'b0);
        chk("fr_startstop_count", current_count, 16'd5);

        // Burst with zero bursts
        do_cfg(8'd0, 4'd0, 2'd1, 8'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b0_busy", busy, 1'b1);
        chk("b0_done_early", done, 1'b0);
        step();
        chk("b0_done", done, 1'b1);
        chk("b0_count", current_count, 16'd0);
        chk("b0_busy_low", busy, 1'b0);
        step();
        chk("b0_done_clear", done, 1'b0);
        chk("b0_ready", cfg_ready, 1'b1);

        // Free-run through the 16-bit wrap, then stop on a tick
        do_cfg(8'd0, 4'd0, 2'd3, 8'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (65534) step();
        chk("wrap_fffe", current_count, 16'hFFFE);
        step();
        chk("wrap_ffff", current_count, 16'hFFFF);
        step();
        chk("wrap_0000", current_count, 16'h0000);
        chk("wrap_tick", tick, 1'b1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("wrap_stop_count", current_count, 16'h0001);
        chk("wrap_stop_busy", busy, 1'b0);
        step();
        chk("wrap_frozen", current_count, 16'h0001);
        chk("wrap_tick_low", tick, 1'b0);

        // Reset mid-run takes effect without a clock edge
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("mr_count", current_count, 16'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rst_count", current_count, 16'd0);
        chk("mr_rst_busy", busy, 1'b0);
        chk("mr_rst_ready", cfg_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Highest rate select
        do_cfg(8'd0, 4'd15, 2'd0, 8'd0);
        chk("rate15_mask", mask, 16'h8000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
